// File: rtl/reaction_sequencer_if.sv
// Reaction sequencer signal bundle: Tick, buttons and LFSR value in; LED,
// LFSR request and result flags out.
// Optional macro BEST_TIME_EN adds the BestTime result port.
interface reaction_sequencer_if #(
    parameter int DELAY_W = 12,
    parameter int COUNT_W = 14
);
    logic               Tick;
    logic               Start;
    logic               Stop;
    logic [DELAY_W-1:0] RandDelay;
    logic               LfsrEnable;
    logic               Led;
    logic [COUNT_W-1:0] ReactTime;
    logic               Valid;
    logic               Cheat;
    logic               Timeout;
    logic               Busy;
`ifdef BEST_TIME_EN
    logic [COUNT_W-1:0] BestTime;
`endif

    // Environment side: buttons, clock divider and LFSR
    modport master (
        output Tick, Start, Stop, RandDelay,
`ifdef BEST_TIME_EN
        input  BestTime,
`endif
        input  LfsrEnable, Led, ReactTime, Valid, Cheat, Timeout, Busy
    );

    // Sequencer side
    modport slave (
        input  Tick, Start, Stop, RandDelay,
`ifdef BEST_TIME_EN
        output BestTime,
`endif
        output LfsrEnable, Led, ReactTime, Valid, Cheat, Timeout, Busy
    );
endinterface

// File: rtl/reaction_sequencer.sv
// Reaction timer trial sequencer: random delay countdown, LED stimulus,
// millisecond reaction count with cheat and timeout detection.
// Optional macro BEST_TIME_EN adds a best-result register on bus.BestTime.
module reaction_sequencer #(
    parameter int DELAY_W    = 12,
    parameter int COUNT_W    = 14,
    parameter int TIMEOUT_MS = 9999
) (
    input logic                 Clock,
    input logic                 Resetn,
    reaction_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_REACT   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [COUNT_W-1:0] TIMEOUT_V = COUNT_W'(TIMEOUT_MS);
    localparam logic [DELAY_W-1:0] DELAY_ONE = DELAY_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    logic [2:0]         state_q, state_d;
    logic               start_q, stop_q;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] react_q, react_d;
    logic               valid_q, valid_d;
    logic               cheat_q, cheat_d;
    logic               timeout_q, timeout_d;
`ifdef BEST_TIME_EN
    logic [COUNT_W-1:0] best_q, best_d;
`endif

    logic               start_press;
    logic               stop_press;
    logic [COUNT_W-1:0] count_inc;
    logic [COUNT_W-1:0] stop_result;

    assign start_press = bus.Start & ~start_q;
    assign stop_press  = bus.Stop & ~stop_q;
    // Saturating increment: the reaction counter never wraps
    assign count_inc   = (count_q == '1) ? count_q : count_q + COUNT_ONE;
    // A Tick coinciding with Stop still counts toward the result
    assign stop_result = bus.Tick ? count_inc : count_q;

    // Next-state and datapath decisions for the trial sequence
    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        count_d   = count_q;
        react_d   = react_q;
        valid_d   = valid_q;
        cheat_d   = cheat_q;
        timeout_d = timeout_q;
`ifdef BEST_TIME_EN
        best_d    = best_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_press) begin
                    valid_d   = 1'b0;
                    cheat_d   = 1'b0;
                    timeout_d = 1'b0;
                    react_d   = '0;
                    count_d   = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                delay_d = (bus.RandDelay == '0) ? DELAY_ONE : bus.RandDelay;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (stop_press) begin
                    cheat_d = 1'b1;
                    state_d = S_DONE;
                end else if (bus.Tick) begin
                    if (delay_q == DELAY_ONE) begin
                        count_d = '0;
                        state_d = S_REACT;
                    end else begin
                        delay_d = delay_q - DELAY_ONE;
                    end
                end
            end
            S_REACT: begin
                if (stop_press) begin
                    react_d = stop_result;
                    valid_d = 1'b1;
                    state_d = S_DONE;
`ifdef BEST_TIME_EN
                    if (stop_result < best_q) begin
                        best_d = stop_result;
                    end
`endif
                end else if (bus.Tick) begin
                    count_d = count_inc;
                    if (count_inc >= TIMEOUT_V) begin
                        timeout_d = 1'b1;
                        react_d   = TIMEOUT_V;
                        state_d   = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; edge detectors track buttons even in reset
    always_ff @(posedge Clock) begin
        start_q <= bus.Start;
        stop_q  <= bus.Stop;
        if (!Resetn) begin
            state_q   <= S_IDLE;
            delay_q   <= '0;
            count_q   <= '0;
            react_q   <= '0;
            valid_q   <= 1'b0;
            cheat_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef BEST_TIME_EN
            best_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            count_q   <= count_d;
            react_q   <= react_d;
            valid_q   <= valid_d;
            cheat_q   <= cheat_d;
            timeout_q <= timeout_d;
`ifdef BEST_TIME_EN
            best_q    <= best_d;
`endif
        end
    end

    assign bus.LfsrEnable = (state_q == S_LOAD);
    assign bus.Led        = (state_q == S_REACT);
    assign bus.Busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.ReactTime  = react_q;
    assign bus.Valid      = valid_q;
    assign bus.Cheat      = cheat_q;
    assign bus.Timeout    = timeout_q;
`ifdef BEST_TIME_EN
    assign bus.BestTime   = best_q;
`endif
endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer: trial-level reference model
// feeding a scoreboard, checked by an independent output monitor.
module tb_reaction_sequencer;
    localparam int DW  = 12;
    localparam int CW  = 14;
    localparam int TMO = 9999;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    reaction_sequencer_if #(.DELAY_W(DW), .COUNT_W(CW)) bus ();

    reaction_sequencer #(
        .DELAY_W(DW),
        .COUNT_W(CW),
        .TIMEOUT_MS(TMO)
    ) dut (
        .Clock (clk),
        .Resetn(rstn),
        .bus   (bus)
    );

    typedef struct {
        bit valid;
        bit cheat;
        bit tmo;
        int rt;
        int wticks;
        int leds;
        int best;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   best_m      = 'h3FFF;

    int   lfsr_cnt  = 0;
    int   led_rises = 0;
    int   wticks    = 0;
    bit   led_prev  = 1'b0;
    bit   done_prev = 1'b0;
    bit   done_now;
    exp_t mon_e;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int gap);
        int g;
        g = (gap == 0) ? $urandom_range(1, 3) : gap;
        bus.Tick = 1'b1;
        step();
        bus.Tick = 1'b0;
        repeat (g) step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!bus.Busy) break;
            step();
        end
        check("trial_completes", bus.Busy, 0);
        step();
    endtask

    // plan 0: Stop after k WAIT ticks (cheat); 1: Stop after k REACT ticks;
    // 2: no Stop (timeout). together puts a Tick in the Stop cycle.
    task automatic run_trial(input int d, input int plan, input int k,
                             input bit together, input bit extra, input int gap);
        exp_t e;
        int   eff;
        eff = (d == 0) ? 1 : d;
        e.valid = 0; e.cheat = 0; e.tmo = 0; e.rt = 0;
        e.wticks = 0; e.leds = 0;
        case (plan)
            0: begin
                e.cheat = 1; e.rt = 0; e.wticks = k + int'(together); e.leds = 0;
            end
            1: begin
                e.valid = 1; e.rt = k + int'(together); e.wticks = eff; e.leds = 1;
                if (e.rt < best_m) best_m = e.rt;
            end
            default: begin
                e.tmo = 1; e.rt = TMO; e.wticks = eff; e.leds = 1;
            end
        endcase
        e.best = best_m;
        sb.push_back(e);

        bus.RandDelay = DW'(d);
        bus.Start = 1'b1;
        step();
        check("lfsr_latency", bus.LfsrEnable, 1);
        bus.Start = 1'b0;
        repeat (3) step();
        if (plan == 0) begin
            repeat (k) tick(gap);
        end else begin
            repeat (eff) tick(gap);
            if (extra) begin
                bus.Start = 1'b1;
                step();
                bus.Start = 1'b0;
                step();
            end
        end
        if (plan == 2) begin
            repeat (TMO) tick(1);
        end else begin
            if (plan == 1) repeat (k) tick(gap);
            bus.Stop = 1'b1;
            bus.Tick = together;
            step();
            if (plan == 1) check("valid_latency", bus.Valid, 1);
            bus.Stop = 1'b0;
            bus.Tick = 1'b0;
            step();
        end
        wait_idle();
    endtask

    // Monitor: accumulate trial observations, compare on each result
    always @(negedge clk) begin
        if (!rstn) begin
            lfsr_cnt  = 0;
            led_rises = 0;
            wticks    = 0;
            led_prev  = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (bus.LfsrEnable) lfsr_cnt++;
            if (bus.Led && !led_prev) led_rises++;
            if (bus.Tick && bus.Busy && !bus.Led && !bus.LfsrEnable) wticks++;
            led_prev = bus.Led;
            done_now = bus.Valid | bus.Cheat | bus.Timeout;
            if (done_now && !done_prev) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got a result, expected none");
                end else begin
                    mon_e = sb.pop_front();
                    check("react_time", bus.ReactTime, mon_e.rt);
                    check("valid", bus.Valid, mon_e.valid);
                    check("cheat", bus.Cheat, mon_e.cheat);
                    check("timeout", bus.Timeout, mon_e.tmo);
                    check("lfsr_pulses", lfsr_cnt, 1);
                    check("led_rises", led_rises, mon_e.leds);
                    check("wait_ticks", wticks, mon_e.wticks);
                    check("led_off_done", bus.Led, 0);
                    check("busy_done", bus.Busy, 0);
`ifdef BEST_TIME_EN
                    check("best_time", bus.BestTime, mon_e.best);
`endif
                end
                lfsr_cnt  = 0;
                led_rises = 0;
                wticks    = 0;
            end
            done_prev = done_now;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d, plan, k, eff;
        bus.Tick = 1'b0;
        bus.Start = 1'b1;
        bus.Stop = 1'b1;
        bus.RandDelay = '0;
        rstn = 1'b0;
        repeat (3) step();
        check("rst_busy", bus.Busy, 0);
        check("rst_led", bus.Led, 0);
        check("rst_lfsr", bus.LfsrEnable, 0);
        rstn = 1'b1;
        repeat (4) step();
        check("held_start_busy", bus.Busy, 0);
        check("held_start_lfsr", bus.LfsrEnable, 0);
        check("held_valid", bus.Valid, 0);
        check("held_cheat", bus.Cheat, 0);
        check("held_timeout", bus.Timeout, 0);
        check("held_react", bus.ReactTime, 0);
`ifdef BEST_TIME_EN
        check("rst_best", bus.BestTime, 'h3FFF);
`endif
        bus.Start = 1'b0;
        bus.Stop = 1'b0;
        step();

        run_trial(2, 1, 300, 0, 0, 1);
        run_trial(2, 1, 250, 0, 0, 1);
        run_trial(6, 0, 2, 0, 0, 1);
        run_trial(2, 1, 400, 0, 0, 1);
        run_trial('h9F0, 1, 217, 0, 0, 1);
        run_trial(30, 0, 10, 0, 0, 1);
        run_trial(5, 1, 41, 1, 0, 1);
        run_trial(0, 1, 7, 0, 0, 1);
        run_trial(4, 0, 3, 1, 0, 1);
        run_trial(3, 2, 0, 0, 0, 1);

        for (int t = 0; t < 24; t++) begin
            d    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            eff  = (d == 0) ? 1 : d;
            plan = ($urandom_range(0, 3) == 0) ? 0 : 1;
            k    = (plan == 0) ? int'($urandom_range(0, eff - 1)) : int'($urandom_range(0, 60));
            run_trial(d, plan, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        // Reset in the middle of REACT
        bus.RandDelay = DW'(5);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        repeat (3) step();
        repeat (8) tick(1);
        check("react_before_reset", bus.Led, 1);
        rstn = 1'b0;
        step();
        check("midreset_led", bus.Led, 0);
        check("midreset_busy", bus.Busy, 0);
        check("midreset_valid", bus.Valid, 0);
        check("midreset_react", bus.ReactTime, 0);
`ifdef BEST_TIME_EN
        check("midreset_best", bus.BestTime, 'h3FFF);
`endif
        rstn = 1'b1;
        best_m = 'h3FFF;
        repeat (5) step();
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
